// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the host/MIPS memory-port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 13;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_HOST = 2'd1,
        RD_MIPS = 2'd2
    } rd_owner_e;

    typedef enum logic {
        SIDE_HOST = 1'b0,
        SIDE_MIPS = 1'b1
    } side_e;

    // Byte address in, word address width out.
    function automatic int word_addr_width(input int byte_aw);
        return byte_aw - 2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signals shared between the host loader, the MIPS core and the arbiter.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    localparam int WAW = word_addr_width(ADDR_WIDTH);

    logic           h_req;
    logic           h_we;
    logic [WAW-1:0] h_addr;
    logic [31:0]    h_wdata;
    logic           h_gnt;
    logic           h_rvalid;
    logic [31:0]    h_rdata;

    logic           m_req;
    logic           m_we;
    logic [WAW-1:0] m_addr;
    logic [31:0]    m_wdata;
    logic           m_gnt;
    logic           m_rvalid;
    logic [31:0]    m_rdata;

    logic [WAW-1:0] mem_addr;
    logic [31:0]    mem_wdata;
    logic           mem_we;
    logic           mem_re;
    logic [31:0]    mem_rdata;

    modport slave (
        input  h_req, h_we, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        input  m_req, m_we, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output h_req, h_we, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        output m_req, m_we, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the ideal-memory port between the host loader and the MIPS core.
// Grants are combinational; read data returns one cycle later to the registered read owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              mips_rst,
    mem_port_arbiter_if.slave bus,
    output logic [31:0]       conflict_cnt
);

    localparam int WORD_AW = word_addr_width(ADDR_WIDTH);

    logic               m_req_e;
    logic               h_win;
    logic               m_win;
    side_e              last_q;
    side_e              last_d;
    rd_owner_e          rd_owner_q;
    rd_owner_e          rd_owner_d;
    logic [WORD_AW-1:0] sel_addr;
    logic [31:0]        sel_wdata;
    logic               sel_we;
    logic               sel_re;
    logic [31:0]        cnt_q;

    assign m_req_e = bus.m_req & ~mips_rst;

    // Gating with the reset keeps every grant and memory strobe low while reset is held.
    always_comb begin
        h_win = 1'b0;
        m_win = 1'b0;
        if (S_AXI_ARESETN) begin
            if (bus.h_req && m_req_e) begin
                h_win = (last_q == SIDE_MIPS);
                m_win = (last_q == SIDE_HOST);
            end else begin
                h_win = bus.h_req;
                m_win = m_req_e;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_re    = 1'b0;
        if (h_win) begin
            sel_addr  = bus.h_addr;
            sel_wdata = bus.h_wdata;
            sel_we    = bus.h_we;
            sel_re    = ~bus.h_we;
        end else if (m_win) begin
            sel_addr  = bus.m_addr;
            sel_wdata = bus.m_wdata;
            sel_we    = bus.m_we;
            sel_re    = ~bus.m_we;
        end
    end

    // Owner moves straight between HOST and MIPS on back-to-back reads; any cycle without a read grant clears it.
    always_comb begin
        last_d     = last_q;
        rd_owner_d = RD_NONE;
        if (h_win) begin
            last_d = SIDE_HOST;
            if (!bus.h_we) rd_owner_d = RD_HOST;
        end else if (m_win) begin
            last_d = SIDE_MIPS;
            if (!bus.m_we) rd_owner_d = RD_MIPS;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            last_q     <= SIDE_MIPS;
            rd_owner_q <= RD_NONE;
        end else begin
            last_q     <= last_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cnt_q <= '0;
        end else if (mips_rst) begin
            cnt_q <= '0;
        end else if (bus.h_req && m_req_e) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign conflict_cnt  = cnt_q;

    assign bus.h_gnt     = h_win;
    assign bus.m_gnt     = m_win;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_we    = sel_we;
    assign bus.mem_re    = sel_re;

    assign bus.h_rvalid  = (rd_owner_q == RD_HOST);
    assign bus.m_rvalid  = (rd_owner_q == RD_MIPS);
    assign bus.h_rdata   = (rd_owner_q == RD_HOST) ? bus.mem_rdata : '0;
    assign bus.m_rdata   = (rd_owner_q == RD_MIPS) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW  = 13;
    localparam int WAW = AW - 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mips_rst;
    logic [31:0] conflict_cnt;
    int          tests_run = 0;
    int          tests_failed = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .mips_rst      (mips_rst),
        .bus           (bus),
        .conflict_cnt  (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Ideal memory: synchronous read, data one cycle after mem_re.
    logic [31:0] mem [0:(1<<WAW)-1];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference model state: 0 = host, 1 = MIPS, -1 = nobody.
    int          mdl_last;
    int          mdl_rv_who;
    logic [31:0] mdl_rv_data;
    logic [31:0] mdl_cnt;
    logic [31:0] shadow [int];

    function automatic void model_reset();
        mdl_last    = 1;
        mdl_rv_who  = -1;
        mdl_rv_data = '0;
        mdl_cnt     = '0;
    endfunction

    function automatic int predict_winner();
        bit h = bus.h_req;
        bit m = bus.m_req && !mips_rst;
        if (h && m) return (mdl_last == 0) ? 1 : 0;
        if (h) return 0;
        if (m) return 1;
        return -1;
    endfunction

    task automatic drive(input bit hr, input bit hw, input int ha, input logic [31:0] hd,
                         input bit mr, input bit mw, input int ma, input logic [31:0] md);
        bus.h_req   = hr;
        bus.h_we    = hw;
        bus.h_addr  = ha[WAW-1:0];
        bus.h_wdata = hd;
        bus.m_req   = mr;
        bus.m_we    = mw;
        bus.m_addr  = ma[WAW-1:0];
        bus.m_wdata = md;
    endtask

    task automatic drive_idle();
        drive(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    // One clock with the currently driven inputs; model advances on the edge; returns at the next negedge.
    task automatic advance();
        int          w = predict_winner();
        bit          conflict = bus.h_req && bus.m_req && !mips_rst;
        bit          mr = mips_rst;
        bit          we = (w == 0) ? bus.h_we : bus.m_we;
        int          a = (w == 0) ? int'(bus.h_addr) : int'(bus.m_addr);
        logic [31:0] d = (w == 0) ? bus.h_wdata : bus.m_wdata;
        @(posedge clk);
        mdl_rv_who = -1;
        if (w >= 0) begin
            mdl_last = w;
            if (we) begin
                shadow[a] = d;
            end else begin
                mdl_rv_who  = w;
                mdl_rv_data = shadow.exists(a) ? shadow[a] : 32'h0;
            end
        end
        if (mr) mdl_cnt = '0;
        else if (conflict) mdl_cnt = mdl_cnt + 32'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1, 0, 5, 32'h0, 1, 0, 6, 32'h0);
        #1;
        tests_run++;
        if ({bus.h_gnt, bus.m_gnt, bus.mem_we, bus.mem_re} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got gnt/we/re %b want 0000",
                     {bus.h_gnt, bus.m_gnt, bus.mem_we, bus.mem_re});
        end
        tests_run++;
        if ({bus.mem_addr, bus.mem_wdata} !== '0 || {bus.h_rvalid, bus.m_rvalid} !== 2'b00 ||
            {bus.h_rdata, bus.m_rdata} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got addr %h wdata %h rv %b%b rdata %h %h want all 0",
                     bus.mem_addr, bus.mem_wdata, bus.h_rvalid, bus.m_rvalid, bus.h_rdata, bus.m_rdata);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (conflict_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %h want 00000000", conflict_cnt);
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_contention();
        bit exp_h [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        drive(1, 1, 1, 32'hA0, 1, 1, 2, 32'hB0);
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (bus.h_gnt !== exp_h[i] || bus.m_gnt !== !exp_h[i]) begin
                tests_failed++;
                $display("FAIL contention_order[%0d]: got h/m %b%b want %b%b",
                         i, bus.h_gnt, bus.m_gnt, exp_h[i], !exp_h[i]);
            end
            advance();
        end
        drive_idle();
        #1;
        tests_run++;
        if (conflict_cnt !== 32'd4) begin
            tests_failed++;
            $display("FAIL contention_cnt: got %0d want 4", conflict_cnt);
        end
        advance();
    endtask

    task automatic test_host_read();
        drive(1, 1, 'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0);
        advance();
        drive(1, 0, 'h10, 32'h0, 0, 0, 0, 32'h0);
        #1;
        tests_run++;
        if ({bus.h_gnt, bus.m_gnt, bus.mem_re, bus.mem_we} !== 4'b1010 || bus.mem_addr !== 11'h010) begin
            tests_failed++;
            $display("FAIL host_read_gnt: got gnt/re/we %b addr %h want 1010 addr 010",
                     {bus.h_gnt, bus.m_gnt, bus.mem_re, bus.mem_we}, bus.mem_addr);
        end
        advance();
        drive_idle();
        #1;
        tests_run++;
        if (bus.h_rvalid !== 1'b1 || bus.h_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL host_read_data: got rvalid %b rdata %h want 1 deadbeef", bus.h_rvalid, bus.h_rdata);
        end
        tests_run++;
        if (bus.m_rvalid !== 1'b0 || bus.m_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL host_read_mside: got m_rvalid %b m_rdata %h want 0 0", bus.m_rvalid, bus.m_rdata);
        end
        advance();
        #1;
        tests_run++;
        if (bus.h_rvalid !== 1'b0 || bus.h_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL host_read_idle: got rvalid %b rdata %h want 0 0", bus.h_rvalid, bus.h_rdata);
        end
    endtask

    task automatic test_mips_mask();
        mips_rst = 1'b1;
        drive_idle();
        advance();
        drive(0, 0, 0, 32'h0, 1, 0, 'h20, 32'h0);
        #1;
        tests_run++;
        if ({bus.m_gnt, bus.mem_re, bus.mem_we} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mask_idle: got m_gnt/re/we %b want 000", {bus.m_gnt, bus.mem_re, bus.mem_we});
        end
        advance();
        drive(1, 0, 'h10, 32'h0, 1, 0, 'h20, 32'h0);
        #1;
        tests_run++;
        if ({bus.h_gnt, bus.m_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL mask_host: got h/m %b want 10", {bus.h_gnt, bus.m_gnt});
        end
        advance();
        drive_idle();
        #1;
        tests_run++;
        if (conflict_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL mask_cnt: got %0d want 0", conflict_cnt);
        end
        mips_rst = 1'b0;
        advance();
    endtask

    task automatic test_write_then_read();
        drive(1, 1, 'h20, 32'h12345678, 0, 0, 0, 32'h0);
        advance();
        drive(0, 0, 0, 32'h0, 1, 0, 'h20, 32'h0);
        #1;
        tests_run++;
        if (bus.m_gnt !== 1'b1 || bus.mem_re !== 1'b1 || bus.mem_addr !== 11'h020) begin
            tests_failed++;
            $display("FAIL raw_gnt: got gnt %b re %b addr %h want 1 1 020", bus.m_gnt, bus.mem_re, bus.mem_addr);
        end
        advance();
        drive_idle();
        #1;
        tests_run++;
        if (bus.m_rvalid !== 1'b1 || bus.m_rdata !== 32'h12345678 || bus.h_rvalid !== 1'b0 || bus.h_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL raw_data: got m %b %h h %b %h want 1 12345678 0 0",
                     bus.m_rvalid, bus.m_rdata, bus.h_rvalid, bus.h_rdata);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 'h10, 32'h0, 1, 0, 'h20, 32'h0);
        #1;
        tests_run++;
        if ({bus.h_gnt, bus.m_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_first: got h/m %b want 10", {bus.h_gnt, bus.m_gnt});
        end
        advance();
        drive(0, 0, 0, 32'h0, 1, 0, 'h20, 32'h0);
        #1;
        tests_run++;
        if (bus.m_gnt !== 1'b1 || bus.h_rvalid !== 1'b1 || bus.h_rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL b2b_second: got m_gnt %b h_rv %b h_rdata %h want 1 1 deadbeef",
                     bus.m_gnt, bus.h_rvalid, bus.h_rdata);
        end
        advance();
        drive_idle();
        #1;
        tests_run++;
        if (bus.m_rvalid !== 1'b1 || bus.m_rdata !== 32'h12345678 || bus.h_rvalid !== 1'b0 || conflict_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL b2b_third: got m_rv %b m_rdata %h h_rv %b cnt %0d want 1 12345678 0 1",
                     bus.m_rvalid, bus.m_rdata, bus.h_rvalid, conflict_cnt);
        end
        advance();
    endtask

    task automatic test_mips_rst_inflight();
        drive(0, 0, 0, 32'h0, 1, 0, 'h20, 32'h0);
        advance();
        mips_rst = 1'b1;
        #1;
        tests_run++;
        if (bus.m_rvalid !== 1'b1 || bus.m_rdata !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL inflight_rvalid: got %b %h want 1 12345678", bus.m_rvalid, bus.m_rdata);
        end
        advance();
        mips_rst = 1'b0;
        drive_idle();
        advance();
    endtask

    task automatic test_cnt_wrap();
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        mdl_cnt = 32'hFFFFFFFF;
        tests_run++;
        if (conflict_cnt !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preset: got %h want ffffffff", conflict_cnt);
        end
        drive(1, 1, 3, 32'h33, 1, 1, 4, 32'h44);
        advance();
        #1;
        tests_run++;
        if (conflict_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_zero: got %h want 00000000", conflict_cnt);
        end
        advance();
        #1;
        tests_run++;
        if (conflict_cnt !== 32'h1) begin
            tests_failed++;
            $display("FAIL wrap_one: got %h want 00000001", conflict_cnt);
        end
        drive_idle();
        mips_rst = 1'b1;
        advance();
        #1;
        tests_run++;
        if (conflict_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_clear: got %h want 00000000", conflict_cnt);
        end
        mips_rst = 1'b0;
        advance();
    endtask

    task automatic test_async_reset_mid_read();
        drive(0, 0, 0, 32'h0, 1, 0, 'h20, 32'h0);
        #1;
        tests_run++;
        if (bus.m_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_pre_gnt: got %b want 1", bus.m_gnt);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.m_gnt !== 1'b0 || bus.mem_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_gnt_drop: got gnt %b re %b want 0 0", bus.m_gnt, bus.mem_re);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.m_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_lost_read: got m_rvalid %b want 0", bus.m_rvalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        advance();
        #1;
        tests_run++;
        if (bus.m_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_read_ok: got m_rvalid %b want 1", bus.m_rvalid);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.m_rvalid !== 1'b0 || bus.m_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL arst_rvalid_drop: got %b %h want 0 0", bus.m_rvalid, bus.m_rdata);
        end
        drive(1, 0, 'h10, 32'h0, 1, 0, 'h20, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if ({bus.h_gnt, bus.m_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL arst_first_tie: got h/m %b want 10", {bus.h_gnt, bus.m_gnt});
        end
        advance();
        drive_idle();
        advance();
    endtask

    task automatic test_random();
        bit          h_act = 1'b0;
        bit          m_act = 1'b0;
        bit          hw = 1'b0;
        bit          mw = 1'b0;
        int          ha = 0;
        int          ma = 0;
        logic [31:0] hd = '0;
        logic [31:0] md = '0;
        for (int a = 0; a < 16; a++) begin
            drive(1, 1, a, $urandom, 0, 0, 0, 32'h0);
            advance();
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int              w;
            bit              wwe;
            logic [5:0]      exp_ctl;
            logic [5:0]      obs_ctl;
            logic [WAW+127:0] exp_dat;
            logic [WAW+127:0] obs_dat;
            mips_rst = ($urandom_range(0, 9) == 0);
            if (!h_act && $urandom_range(0, 3) != 0) begin
                h_act = 1'b1; hw = 1'($urandom_range(0, 1)); ha = $urandom_range(0, 15); hd = $urandom;
            end else if (h_act && $urandom_range(0, 15) == 0) begin
                h_act = 1'b0;
            end
            if (!m_act && $urandom_range(0, 3) != 0) begin
                m_act = 1'b1; mw = 1'($urandom_range(0, 1)); ma = $urandom_range(0, 15); md = $urandom;
            end else if (m_act && $urandom_range(0, 15) == 0) begin
                m_act = 1'b0;
            end
            drive(h_act, hw, ha, hd, m_act, mw, ma, md);
            #1;
            w   = predict_winner();
            wwe = (w == 0) ? hw : mw;
            exp_ctl = {w == 0, w == 1, (w >= 0) && wwe, (w >= 0) && !wwe, mdl_rv_who == 0, mdl_rv_who == 1};
            obs_ctl = {bus.h_gnt, bus.m_gnt, bus.mem_we, bus.mem_re, bus.h_rvalid, bus.m_rvalid};
            tests_run++;
            if (obs_ctl !== exp_ctl) begin
                tests_failed++;
                $display("FAIL random_ctl[%0d]: got gnt/we/re/rv %b want %b", cyc, obs_ctl, exp_ctl);
            end
            exp_dat = {(w == 0) ? WAW'(ha) : (w == 1) ? WAW'(ma) : WAW'(0),
                       (w == 0) ? hd : (w == 1) ? md : 32'h0,
                       (mdl_rv_who == 0) ? mdl_rv_data : 32'h0,
                       (mdl_rv_who == 1) ? mdl_rv_data : 32'h0,
                       mdl_cnt};
            obs_dat = {bus.mem_addr, bus.mem_wdata, bus.h_rdata, bus.m_rdata, conflict_cnt};
            tests_run++;
            if (obs_dat !== exp_dat) begin
                tests_failed++;
                $display("FAIL random_data[%0d]: got addr/wdata/hrd/mrd/cnt %h want %h", cyc, obs_dat, exp_dat);
            end
            advance();
            if (w == 0) h_act = 1'b0;
            if (w == 1) m_act = 1'b0;
        end
        mips_rst = 1'b0;
        drive_idle();
        advance();
    endtask

    initial begin
        rst_n    = 1'b0;
        mips_rst = 1'b0;
        drive_idle();
        model_reset();
        test_reset();
        test_contention();
        test_host_read();
        test_mips_mask();
        test_write_then_read();
        test_back_to_back();
        test_mips_rst_inflight();
        test_cnt_wrap();
        test_async_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single port of the MIPS ideal memory between two requesters: the ARM-side AXI Lite slave (host loader) and the MIPS core. It arbitrates per cycle with round-robin fairness, drives the memory port, and returns read data with a one-cycle latency to the winning requester. It also counts conflict stall cycles, which are exported for use as a performance counter.

## Interface
- ADDR_WIDTH, 13: byte address width of the memory region. Word address width is ADDR_WIDTH-2.
- S_AXI_ACLK  in  1  single clock for the block and the memory.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- mips_rst  in  1  MIPS reset. While high, MIPS requests are masked.
- h_req, h_we  in  1 each  host request; host write (1) or read (0).
- h_addr  in  ADDR_WIDTH-2  host word address.
- h_wdata  in  32  host write data.
- h_gnt  out  1  host request accepted this cycle.
- h_rvalid  out  1  host read data valid.
- h_rdata  out  32  host read data.
- m_req, m_we, m_addr, m_wdata, m_gnt, m_rvalid, m_rdata: MIPS-side counterparts, same widths and meanings.
- mem_addr  out  ADDR_WIDTH-2  memory word address.
- mem_wdata  out  32  memory write data.
- mem_we, mem_re  out  1 each  memory write and read strobes.
- mem_rdata  in  32  memory read data, valid the cycle after mem_re.
- conflict_cnt  out  32  cycles in which a valid request was denied.

## Operation
- Effective MIPS request: m_req_e = m_req & ~mips_rst.
- Grant is combinational within the cycle:
  - One requester active: it is granted.
  - Both active: the requester not granted most recently wins. This is tracked by a 1-bit pointer `last` (0 = host, 1 = MIPS).
- `last` updates at the clock edge to the winner whenever any grant occurs. It holds otherwise.
- Memory port when granted: mem_addr/mem_wdata come from the winner.
  - mem_we = winner's we.
  - mem_re = ~winner's we.
- Memory port when idle: mem_we = mem_re = 0, mem_addr = 0, mem_wdata = 0.
- Requesters hold req/we/addr/wdata stable until gnt is seen. A dropped request before gnt is allowed and has no side effect.
- Read return:
  - A registered `rd_owner` (2 bits: none, host, MIPS) captures the read winner.
  - The next cycle, the owner's rvalid = 1 and its rdata = mem_rdata.
  - The non-owner's rdata = 0.
- Writes produce no rvalid. A write is complete at gnt.
- conflict_cnt:
  - Increments by 1 in every cycle where h_req & m_req_e.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared synchronously while mips_rst = 1, so it reflects the current MIPS run.
- States of `rd_owner`:
  - NONE → HOST on a host read grant.
  - NONE → MIPS on a MIPS read grant.
  - Any state → NONE on a cycle with no read grant.
  - HOST/MIPS → HOST/MIPS directly on back-to-back reads. No idle cycle is required.

## Timing
- Reset (ARESETN low, async): last = 1, so the host wins the first tie. rd_owner = NONE, conflict_cnt = 0.
- All outputs are 0 during reset: gnt, rvalid, rdata, and mem_* outputs.
- Grant latency 0: a request granted in cycle N shows gnt high in cycle N.
- Read data latency 1: granted in N, rvalid/rdata appear in N+1.
- Throughput is one access per cycle. Two contending requesters alternate on every cycle.
- Starvation bound: a held request waits at most 1 cycle.
- Write then read to the same address in consecutive cycles: the read returns the new data (memory write-first).
- mips_rst rising while MIPS has a read in flight (rd_owner = MIPS): m_rvalid is still asserted in N+1. MIPS state reset is the core's responsibility.
- Async reset asserted mid-read: rvalid is dropped immediately and the read is lost.

## Structure
- Shared package constants: RD_NONE=2'd0, RD_HOST=2'd1, RD_MIPS=2'd2.
- Word-address width is defined as ADDR_WIDTH-2.
- Single module, with no sub-modules. The grant logic, `last` flop, rd_owner register and counter all sit in one file.
- The host side connects to the AXI Lite slave's memory signals. The core's memory port connects to the m_* signals.

## Test plan
- Host only: read addr 0x010 with mem holding 0xDEADBEEF → h_gnt same cycle, h_rvalid=1 next cycle, h_rdata=0xDEADBEEF, m_rvalid=0.
- Both requesters held for 4 cycles after reset → grant order H, M, H, M; conflict_cnt=4.
- mips_rst=1 with m_req=1, and host idle → m_gnt=0, mem_re=mem_we=0, conflict_cnt stays 0.
- Host writes 0x12345678 to 0x020 in cycle N; MIPS reads 0x020 in N+1 → m_rdata=0x12345678 in N+2.
- conflict_cnt preset near 0xFFFFFFFF, then 2 conflict cycles → value wraps to 0x00000000 then 0x00000001. mips_rst=1 → cleared to 0.
- Async reset mid MIPS read (after gnt, before rvalid) → m_rvalid stays 0. After release, the first tie goes to the host.
